uart_image_buffer: RTL and testbench
====================================

# uart_image_buffer

Collects the byte stream produced by `uart_receiver` into one 28×28 8-bit image frame and holds it for the neural-network datapath. It sits directly downstream of `uart_receiver`: its `data_out`/`valid` feed this block's `rx_data`/`rx_valid`. Once all 784 pixels have arrived, the block signals frame-ready, serves random-access pixel reads, and waits for an acknowledge before it accepts the next frame. Stalled partial frames are discarded by an inter-byte timeout.

## Interface
- `IMG_W`, default 28: image width in pixels.
- `IMG_H`, default 28: image height in pixels.
- `PIX_W`, default 8: pixel width; must equal the UART byte width.
- `TIMEOUT_CYCLES`, default 17360: idle clocks allowed between bytes during a load. This is 2 byte-times at 100 MHz / 115200 baud.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in `PIX_W`: byte from `uart_receiver`.
- `rx_valid` in 1: byte-valid from `uart_receiver`. Either a one-cycle strobe or a held level is accepted.
- `rd_addr` in `ADDR_W`: pixel read address, row-major (`row*IMG_W+col`).
- `rd_data` out `PIX_W`: registered read data.
- `frame_ready` out 1: a complete frame is held.
- `frame_ack` in 1: consumer has finished with the frame.
- `frame_error` out 1: one-cycle pulse when a partial frame is discarded on timeout.
- `overrun` out 1: one-cycle pulse when a byte is dropped in READY.
- `pix_count` out `ADDR_W`: pixels written in the current frame.

## Operation
- `NUM_PIX = IMG_W*IMG_H` (784). `ADDR_W = $clog2(NUM_PIX)` (10).
- Byte detection:
  - `rx_valid` is registered into `rx_valid_q`.
  - A byte event is `rx_valid & ~rx_valid_q`.
  - A level held for N cycles therefore counts as exactly one byte.
- The state machine has three states, IDLE → LOAD → READY → IDLE:
  - **IDLE**: `pix_count`=0. A byte event writes `mem[0]`, sets `pix_count`=1 and moves to LOAD.
  - **LOAD**:
    - A byte event writes `mem[pix_count]` and increments `pix_count`.
    - The byte that makes `pix_count` reach `NUM_PIX` moves the machine to READY.
    - The timeout counter reloads on every byte event. When it reaches `TIMEOUT_CYCLES` with no event: pulse `frame_error`, `pix_count`←0, go to IDLE.
  - **READY**:
    - `frame_ready`=1.
    - A byte event writes nothing and pulses `overrun`.
    - `frame_ack` moves the machine to IDLE and clears `pix_count`.
- Boundary and concurrent-event rules:
  - A byte event and timeout expiry in the same cycle: the byte wins (it is written and the timeout reloads).
  - `frame_ack` and a byte event in the same cycle in READY: the byte is dropped with `overrun`, and the machine still goes to IDLE.
  - `frame_ack` outside READY is ignored.
- Reads:
  - Reads are legal in every state. Contents are only guaranteed while `frame_ready`=1.
  - `rd_addr` ≥ `NUM_PIX` returns 0.
- Reset, including mid-LOAD: state IDLE, `pix_count` 0, timeout 0, `rx_valid_q` 0. Memory is not cleared.

## Timing
- Reset values:
  - `frame_ready`=0
  - `frame_error`=0
  - `overrun`=0
  - `pix_count`=0
  - `rd_data`=0
- Write latency: the memory write and the `pix_count` update are visible the cycle after the byte event.
- `frame_ready` rises the cycle after the event for byte 784.
- `frame_ready` falls the cycle after `frame_ack` is sampled high.
- `rd_data` has one-cycle read latency from `rd_addr`.
- `frame_error` and `overrun` are single-cycle registered pulses.
- The timeout counter runs only in LOAD and is cleared in all other states.

## Structure
- The shared package `image_pkg` holds:
  - `IMG_W`, `IMG_H`, `NUM_PIX`, `ADDR_W`
  - `pixel_t` (logic [7:0])
  - `buf_state_t` enum {IDLE, LOAD, READY}
- One sub-module, `pixel_ram`: simple dual-port RAM of `NUM_PIX`×`PIX_W`, with one synchronous write port, one synchronous read port and no reset, so it is BRAM-inferable.
- The top level holds the edge detector, the FSM, `pix_count`, the timeout counter and the out-of-range read mux.

## Test plan
- **Full frame**: send a full frame with byte k = k mod 256, as 784 one-cycle strobes.
  - `frame_ready`=1 one cycle after byte 784, and `pix_count`=784.
  - Reads return `rd_addr` 29 → 29 and `rd_addr` 783 → 15.
  - `rd_addr` 800 → 0.
- **Held valid**: hold `rx_valid` high for 3 cycles with `rx_data`=0xA5 while in IDLE.
  - Exactly one write: `pix_count`=1 and `mem[0]`=0xA5.
- **Timeout**: send 100 bytes, then stay idle for `TIMEOUT_CYCLES`.
  - One `frame_error` pulse and `pix_count`=0.
  - A following full frame loads from address 0 and raises `frame_ready`.
- **Overrun and ack**: in READY, send byte 0xFF.
  - One `overrun` pulse and `mem[0]` unchanged.
  - Assert `frame_ack` → `frame_ready`=0 next cycle.
  - Assert `frame_ack` again in IDLE → no effect.
- **Reset mid-load**: reset after 400 bytes.
  - `frame_ready`=0 and `pix_count`=0.
  - The next 784 bytes form a valid frame: `rd_addr` 0 returns the first post-reset byte.
- **Simultaneous byte and timeout**: in LOAD, deliver a byte event in the expiry cycle.
  - No `frame_error`, and the byte is written.

Source files
------------

// File: rtl/image_pkg.sv
// Shared definitions for the UART image buffer.
//   IMG_W, IMG_H : default image geometry (28x28)
//   NUM_PIX      : pixels per frame
//   ADDR_W       : pixel address width
//   pixel_t      : one 8-bit pixel
//   buf_state_t  : frame-buffer state machine encoding
package image_pkg;

    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int NUM_PIX = IMG_W * IMG_H;
    localparam int ADDR_W  = $clog2(NUM_PIX);

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } buf_state_t;

endpackage

// File: rtl/pixel_ram.sv
// Simple dual-port pixel memory: one synchronous write port, one synchronous
// read port, no reset so it maps onto block RAM.
//   clk     : clock
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : registered read data (old contents on a same-address write)
module pixel_ram #(
    parameter int DEPTH = image_pkg::NUM_PIX,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_image_buffer.sv
// Collects a UART byte stream into one IMG_W x IMG_H frame, holds it for
// random-access reads until acknowledged, and drops stalled partial frames.
//   clk, reset  : clock, synchronous active-high reset
//   rx_data     : byte from the UART receiver
//   rx_valid    : byte valid (strobe or held level; rising edge = one byte)
//   rd_addr     : row-major pixel read address
//   rd_data     : registered read data, 0 for addresses past the frame
//   frame_ready : complete frame held
//   frame_ack   : consumer done with the frame (only honoured in READY)
//   frame_error : one-cycle pulse when a partial frame times out
//   overrun     : one-cycle pulse when a byte arrives while a frame is held
//   pix_count   : pixels written in the current frame
module uart_image_buffer #(
    parameter int IMG_W          = 28,
    parameter int IMG_H          = 28,
    parameter int PIX_W          = 8,
    parameter int TIMEOUT_CYCLES = 17360,
    localparam int NUM_PIX       = IMG_W * IMG_H,
    localparam int ADDR_W        = $clog2(NUM_PIX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PIX_W-1:0]  rx_data,
    input  logic              rx_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              frame_error,
    output logic              overrun,
    output logic [ADDR_W-1:0] pix_count
);

    import image_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    buf_state_t        state_q;
    logic [ADDR_W-1:0] pix_count_q;
    logic [TW-1:0]     tmo_q;
    logic              rx_valid_q;
    logic              err_q;
    logic              ovr_q;
    logic              rd_zero_q;
    logic [PIX_W-1:0]  ram_rd_data;
    logic              byte_evt;
    logic              ram_we;

    assign byte_evt = rx_valid & ~rx_valid_q;
    // pix_count is 0 in IDLE, so it doubles as the write address in IDLE and LOAD.
    assign ram_we   = byte_evt & (state_q != READY);

    pixel_ram #(
        .DEPTH (NUM_PIX),
        .WIDTH (PIX_W),
        .AW    (ADDR_W)
    ) u_pixel_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (pix_count_q),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pix_count_q <= '0;
            tmo_q       <= '0;
            rx_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            rd_zero_q   <= 1'b1;  // forces rd_data to 0 out of reset (RAM has no reset)
        end else begin
            rx_valid_q <= rx_valid;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            rd_zero_q  <= (rd_addr >= ADDR_W'(NUM_PIX));
            unique case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (byte_evt) begin
                        pix_count_q <= ADDR_W'(1);
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    // A byte in the expiry cycle wins over the timeout.
                    if (byte_evt) begin
                        tmo_q       <= '0;
                        pix_count_q <= pix_count_q + ADDR_W'(1);
                        if (pix_count_q == ADDR_W'(NUM_PIX - 1)) begin
                            state_q <= READY;
                        end
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_q       <= 1'b1;
                        pix_count_q <= '0;
                        tmo_q       <= '0;
                        state_q     <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                READY: begin
                    tmo_q <= '0;
                    ovr_q <= byte_evt;
                    if (frame_ack) begin
                        pix_count_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_data     = rd_zero_q ? '0 : ram_rd_data;
    assign frame_ready = (state_q == READY);
    assign frame_error = err_q;
    assign overrun     = ovr_q;
    assign pix_count   = pix_count_q;

endmodule

// File: tb/tb_uart_image_buffer.sv
// Randomized self-checking bench for uart_image_buffer against a frame-level
// reference model (byte list, fill count, idle-cycle count).
module tb_uart_image_buffer;

    localparam int T   = 300;
    localparam int NUM = 784;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ready;
    logic       frame_ack;
    logic       frame_error;
    logic       overrun;
    logic [9:0] pix_count;

    always #5 clk = ~clk;

    uart_image_buffer #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_ack   (frame_ack),
        .frame_error (frame_error),
        .overrun     (overrun),
        .pix_count   (pix_count)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: 0 = empty, 1 = filling, 2 = frame held.
    int           m_mode = 0;
    int           m_cnt  = 0;
    int           m_idle = 0;
    bit           m_pv   = 0;
    byte unsigned m_mem   [NUM];
    bit           m_known [NUM];

    int err_seen = 0;
    int ovr_seen = 0;
    bit rand_rd  = 1;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        bit ev;
        bit e_err;
        bit e_ovr;
        bit rd_chk;
        int rd_exp;
        if (rand_rd) rd_addr = 10'($urandom_range(0, 1023));
        @(posedge clk);
        ev     = rx_valid && !m_pv;
        e_err  = 0;
        e_ovr  = 0;
        rd_chk = 1;
        if (rd_addr >= NUM) begin
            rd_exp = 0;
        end else begin
            rd_exp = m_mem[rd_addr];
            rd_chk = m_known[rd_addr];
        end
        if (reset) begin
            m_mode = 0;
            m_cnt  = 0;
            m_idle = 0;
            m_pv   = 0;
            rd_exp = 0;
            rd_chk = 1;
        end else begin
            m_pv = rx_valid;
            if (m_mode == 0) begin
                if (ev) begin
                    m_mem[0]   = rx_data;
                    m_known[0] = 1;
                    m_cnt      = 1;
                    m_idle     = 0;
                    m_mode     = 1;
                end
            end else if (m_mode == 1) begin
                if (ev) begin
                    m_mem[m_cnt]   = rx_data;
                    m_known[m_cnt] = 1;
                    m_cnt++;
                    m_idle = 0;
                    if (m_cnt == NUM) m_mode = 2;
                end else begin
                    m_idle++;
                    if (m_idle == T) begin
                        e_err  = 1;
                        m_cnt  = 0;
                        m_idle = 0;
                        m_mode = 0;
                    end
                end
            end else begin
                e_ovr = ev;
                if (frame_ack) begin
                    m_mode = 0;
                    m_cnt  = 0;
                end
            end
        end
        #1;
        check_eq("frame_ready", frame_ready, (m_mode == 2));
        check_eq("frame_error", frame_error, e_err);
        check_eq("overrun", overrun, e_ovr);
        check_eq("pix_count", pix_count, m_cnt);
        if (rd_chk) check_eq("rd_data", rd_data, rd_exp);
        err_seen += int'(frame_error);
        ovr_seen += int'(overrun);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
        repeat (gap) tick();
    endtask

    // seq=1: byte k = k mod 256 as one-cycle strobes; seq=0: random data and gaps.
    task automatic send_bytes(input int n, input bit seq, output logic [7:0] first);
        logic [7:0] d;
        first = 8'h00;
        for (int k = 0; k < n; k++) begin
            d = seq ? 8'(k % 256) : 8'($urandom_range(0, 255));
            if (k == 0) first = d;
            send_byte(d, seq ? 1 : int'($urandom_range(1, 3)));
        end
    endtask

    task automatic read_pix(input int addr, input int exp, input string tag);
        rand_rd = 0;
        rd_addr = 10'(addr);
        tick();
        check_eq(tag, rd_data, exp);
        rand_rd = 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] first;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        frame_ack = 1'b0;
        rd_addr   = '0;

        do_reset();
        check_eq("reset_ready", frame_ready, 0);
        check_eq("reset_error", frame_error, 0);
        check_eq("reset_overrun", overrun, 0);
        check_eq("reset_count", pix_count, 0);
        check_eq("reset_rd", rd_data, 0);

        // Full frame of one-cycle strobes; frame_ready right after byte 784.
        send_bytes(NUM - 1, 1'b1, first);
        check_eq("ready_before_last", frame_ready, 0);
        rx_data  = 8'((NUM - 1) % 256);
        rx_valid = 1'b1;
        tick();
        check_eq("ready_after_last", frame_ready, 1);
        check_eq("count_full", pix_count, NUM);
        rx_valid = 1'b0;
        tick();
        read_pix(29, 29, "rd_29");
        read_pix(783, 15, "rd_783");
        read_pix(800, 0, "rd_800");

        // Overrun in READY, then ack, then a stray ack in IDLE.
        ovr_seen = 0;
        send_byte(8'hFF, 1);
        check_eq("overrun_pulses", ovr_seen, 1);
        read_pix(0, 0, "rd_0_after_overrun");
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check_eq("ready_after_ack", frame_ready, 0);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        tick();
        check_eq("idle_ack_ready", frame_ready, 0);
        check_eq("idle_ack_count", pix_count, 0);

        // Held valid counts as one byte.
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (3) tick();
        rx_valid = 1'b0;
        tick();
        check_eq("held_count", pix_count, 1);
        read_pix(0, 8'hA5, "held_rd_0");

        // Timeout after 100 bytes total.
        send_bytes(99, 1'b0, first);
        check_eq("count_100", pix_count, 100);
        err_seen = 0;
        repeat (T + 5) tick();
        check_eq("timeout_pulses", err_seen, 1);
        check_eq("timeout_count", pix_count, 0);

        // Fresh random frame after the timeout.
        send_bytes(NUM, 1'b0, first);
        check_eq("ready_after_timeout", frame_ready, 1);
        read_pix(0, first, "rd_0_after_timeout");

        // Ack and a byte in the same cycle: byte dropped, still leaves READY.
        ovr_seen  = 0;
        rx_data   = 8'h3C;
        rx_valid  = 1'b1;
        frame_ack = 1'b1;
        tick();
        rx_valid  = 1'b0;
        frame_ack = 1'b0;
        tick();
        check_eq("ack_byte_overrun", ovr_seen, 1);
        check_eq("ack_byte_ready", frame_ready, 0);
        check_eq("ack_byte_count", pix_count, 0);

        // Reset mid-load.
        send_bytes(400, 1'b0, first);
        do_reset();
        check_eq("midload_ready", frame_ready, 0);
        check_eq("midload_count", pix_count, 0);
        send_bytes(NUM, 1'b0, first);
        check_eq("post_reset_ready", frame_ready, 1);
        read_pix(0, first, "post_reset_rd_0");
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        tick();

        // Byte event in the timeout expiry cycle.
        send_bytes(4, 1'b0, first);
        send_byte(8'h11, 1);
        repeat (T - 2) tick();
        err_seen = 0;
        send_byte(8'h5A, 1);
        check_eq("race_no_error", err_seen, 0);
        check_eq("race_count", pix_count, 6);
        read_pix(5, 8'h5A, "race_rd_5");
        repeat (T + 5) tick();
        check_eq("race_later_timeout", err_seen, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
